// File: rtl/led_hex_pattern.sv
// led_hex_pattern: selectable LED animation plus a hex step counter on
// seven-segment digits, both advanced by a prescaled clock-enable tick.
module led_hex_pattern #(
  parameter int LED_W      = 10,
  parameter int HEX_N      = 1,
  parameter int PRESCALE_W = 16,
  parameter bit BLANK_LZ   = 1'b0
) (
  input  logic               clkIn,
  input  logic               rst_n,
  input  logic [3:0]         divide,
  input  logic               enable,
  input  logic [1:0]         mode,
  output logic [LED_W-1:0]   LEDR,
  output logic [7*HEX_N-1:0] HEX,
  output logic               tick_o
);

  localparam int PW = PRESCALE_W + 15;
  localparam int HW = 4 * HEX_N;
  localparam logic [PW-1:0] ONES = '1;

  typedef enum logic [1:0] {
    M_CHASE,
    M_BOUNCE,
    M_FILL,
    M_COUNT
  } mode_e;

  typedef enum logic {
    DIR_UP,
    DIR_DN
  } dir_e;

  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic [PW-1:0]      term;
  logic               tick;
  mode_e              mode_in;
  mode_e              mode_q, mode_d;
  dir_e               dir_q, dir_d;
  logic [LED_W-1:0]   pat_q, pat_d;
  logic [HW-1:0]      hcnt_q, hcnt_d;
  logic [LED_W-1:0]   ledr_d;
  logic [7*HEX_N-1:0] hex_d;
  logic               hi_zero;

  function automatic logic [LED_W-1:0] start_pat(input mode_e m);
    if (m == M_CHASE || m == M_BOUNCE) begin
      return LED_W'(1);
    end
    return '0;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Shifting past the counter width yields zero, so term saturates to all-ones.
  assign term    = ~(ONES << (PRESCALE_W + 32'(divide)));
  assign mode_in = mode_e'(mode);

  always_comb begin
    tick   = enable && (pcnt_q >= term);
    pcnt_d = pcnt_q;
    if (tick) begin
      pcnt_d = '0;
    end else if (enable) begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    pat_d  = pat_q;
    if (mode_in != mode_q) begin
      mode_d = mode_in;
      dir_d  = DIR_UP;
      pat_d  = start_pat(mode_in);
    end else if (tick) begin
      unique case (mode_q)
        M_CHASE: begin
          pat_d = pat_q[LED_W-1] ? LED_W'(1) : (pat_q << 1);
        end
        M_BOUNCE: begin
          if (dir_q == DIR_UP) begin
            pat_d = pat_q << 1;
            if (pat_d[LED_W-1]) dir_d = DIR_DN;
          end else begin
            pat_d = pat_q >> 1;
            if (pat_d[0]) dir_d = DIR_UP;
          end
        end
        M_FILL: begin
          pat_d = (&pat_q) ? '0 : {pat_q[LED_W-2:0], 1'b1};
        end
        default: begin
          pat_d = pat_q + LED_W'(1);
        end
      endcase
    end
  end

  assign hcnt_d = tick ? hcnt_q + HW'(1) : hcnt_q;
  assign ledr_d = enable ? pat_d : '0;

  // Scan from the top digit so hi_zero means "this and every higher digit is 0".
  always_comb begin
    hi_zero = 1'b1;
    hex_d   = '1;
    for (int d = HEX_N - 1; d >= 0; d--) begin
      hi_zero = hi_zero && (hcnt_d[4*d +: 4] == 4'h0);
      if (BLANK_LZ && d > 0 && hi_zero) begin
        hex_d[7*d +: 7] = 7'h7F;
      end else begin
        hex_d[7*d +: 7] = seg7(hcnt_d[4*d +: 4]);
      end
    end
    if (!enable) begin
      hex_d = '1;
    end
  end

  // Reset parks mode_q at chase; a different mode at the first clock reloads
  // pat through the mode-change path, giving start(mode) on that edge.
  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      mode_q <= M_CHASE;
      dir_q  <= DIR_UP;
      pat_q  <= LED_W'(1);
      hcnt_q <= '0;
      LEDR   <= '0;
      HEX    <= '1;
      tick_o <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      pat_q  <= pat_d;
      hcnt_q <= hcnt_d;
      LEDR   <= ledr_d;
      HEX    <= hex_d;
      tick_o <= tick;
    end
  end

endmodule

// File: tb/tb_led_hex_pattern.sv
// tb_led_hex_pattern: directed and randomized steps checked against a
// step-count reference model of the LED animations and hex counter.
module tb_led_hex_pattern;

  localparam int LW = 4;
  localparam int HN = 2;
  localparam int PS = 2;
  localparam logic [7*HN-1:0] HEX_OFF = '1;
  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [3:0]     divide;
  logic           enable;
  logic [1:0]     mode;
  logic [LW-1:0]  ledr;
  logic [7*HN-1:0] hex;
  logic           tick;

  led_hex_pattern #(
    .LED_W(LW), .HEX_N(HN), .PRESCALE_W(PS), .BLANK_LZ(1'b1)
  ) dut (
    .clkIn(clk), .rst_n(rst_n), .divide(divide), .enable(enable),
    .mode(mode), .LEDR(ledr), .HEX(hex), .tick_o(tick)
  );

  int checks = 0;
  int failures = 0;
  int m_pcnt, m_steps, m_ticks;
  logic [1:0] m_mode;
  bit last_tick;

  function automatic logic [LW-1:0] pat_of(input logic [1:0] m, input int s);
    int p;
    case (m)
      2'd0: return LW'(1 << (s % LW));
      2'd1: begin
        p = s % (2*LW - 2);
        if (p >= LW) p = 2*LW - 2 - p;
        return LW'(1 << p);
      end
      2'd2: return LW'((1 << (s % (LW + 1))) - 1);
      default: return LW'(s % (1 << LW));
    endcase
  endfunction

  function automatic logic [7*HN-1:0] hex_of(input int v);
    int hi, lo;
    hi = (v >> 4) & 15;
    lo = v & 15;
    return {(hi == 0) ? 7'h7F : SEG[hi], SEG[lo]};
  endfunction

  function automatic int term_of(input logic [3:0] d);
    return (1 << (PS + int'(d))) - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    bit t;
    t = enable && (m_pcnt >= term_of(divide));
    if (mode != m_mode) begin
      m_mode  = mode;
      m_steps = 0;
    end else if (t) begin
      m_steps++;
    end
    if (t) begin
      m_ticks = (m_ticks + 1) % 256;
      m_pcnt  = 0;
    end else if (enable) begin
      m_pcnt++;
    end
    last_tick = t;
    @(posedge clk);
    #1;
    check("LEDR", 32'(ledr), enable ? 32'(pat_of(m_mode, m_steps)) : 32'd0);
    check("HEX", 32'(hex), enable ? 32'(hex_of(m_ticks)) : 32'(HEX_OFF));
    check("tick_o", 32'(tick), 32'(t));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_LEDR"}, 32'(ledr), 32'd0);
    check({tag, "_HEX"}, 32'(hex), 32'(HEX_OFF));
    check({tag, "_tick"}, 32'(tick), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_pcnt  = 0;
    m_mode  = mode;
    m_steps = 0;
    m_ticks = 0;
  endtask

  initial begin
    bit found;
    rst_n  = 1'b1;
    divide = 4'd0;
    enable = 1'b1;
    mode   = 2'd0;
    #2 rst_n = 1'b0;
    #1 reset_checks("rst");
    release_reset();

    // First edge after release: start pattern and digit 0.
    cycle();
    check("first_LEDR", 32'(ledr), 32'h1);
    check("first_HEX", 32'(hex), 32'h3FC0);
    run(20);

    mode = 2'd1;
    run(40);
    mode = 2'd2;
    run(30);
    mode = 2'd3;
    run(70);

    // Mode switch in the same cycle as a tick: no step, start value shown.
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (m_pcnt == term_of(divide)) found = 1;
      else cycle();
    end
    check("sync_reach", 32'(found), 32'd1);
    mode = 2'd0;
    cycle();
    check("sync_tick", 32'(tick), 32'd1);
    check("sync_LEDR", 32'(ledr), 32'h1);
    run(12);

    // divide 3 -> 0 at pcnt 20 ticks on the very next edge.
    divide = 4'd3;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_pcnt == 20) found = 1;
      else cycle();
    end
    check("div_reach", 32'(found), 32'd1);
    divide = 4'd0;
    cycle();
    check("div_tick", 32'(tick), 32'd1);
    run(12);
    divide = 4'd1;
    run(40);

    mode = 2'd1;
    run(13);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(30);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 19))
        0: mode = 2'($urandom_range(0, 3));
        1: enable = ($urandom_range(0, 3) != 0);
        2: divide = 4'($urandom_range(0, 2));
        default: ;
      endcase
      cycle();
    end

    // Hex counter boundaries: blanked leading zero, carry, wrap.
    enable = 1'b1;
    divide = 4'd0;
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      cycle();
      if (last_tick && m_ticks == 15) found = 1;
    end
    check("h0F_reach", 32'(found), 32'd1);
    check("h0F_HEX", 32'(hex), 32'h3F8E);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (last_tick) found = 1;
    end
    check("h10_HEX", 32'(hex), 32'h3CC0);
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      cycle();
      if (last_tick && m_ticks == 0) found = 1;
    end
    check("wrap_reach", 32'(found), 32'd1);
    check("wrap_HEX", 32'(hex), 32'h3FC0);

    // Asynchronous reset mid-count.
    run(6);
    #2 rst_n = 1'b0;
    #1 reset_checks("midrst");
    mode = 2'd2;
    release_reset();
    run(25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
